// File: rtl/spiflash_arb.sv
// Two-requester round-robin arbiter in front of a SPI flash read port, with a read timeout.
// Optional one-entry read cache compiled in with `define SPIFLASH_ARB_CACHE_EN.
module spiflash_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [23:0] m0_addr,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic [23:0] m1_addr,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_valid,
    output logic [23:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_valid_q, mem_valid_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic        m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
    logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic        m0_err_q, m0_err_d, m1_err_q, m1_err_d;
`ifdef SPIFLASH_ARB_CACHE_EN
    logic        cvalid_q, cvalid_d;
    logic [23:0] ctag_q, ctag_d;
    logic [31:0] cdata_q, cdata_d;
`endif

    logic        win, hit, resp_fire, resp_err;
    logic [23:0] win_addr;
    logic [31:0] resp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            m0_ready_q  <= 1'b0;
            m1_ready_q  <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
`ifdef SPIFLASH_ARB_CACHE_EN
            cvalid_q    <= 1'b0;
            ctag_q      <= '0;
            cdata_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            m0_ready_q  <= m0_ready_d;
            m1_ready_q  <= m1_ready_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_err_q    <= m0_err_d;
            m1_err_q    <= m1_err_d;
`ifdef SPIFLASH_ARB_CACHE_EN
            cvalid_q    <= cvalid_d;
            ctag_q      <= ctag_d;
            cdata_q     <= cdata_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_valid_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        m0_ready_d  = 1'b0;
        m1_ready_d  = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        m0_err_d    = m0_err_q;
        m1_err_d    = m1_err_q;
        win         = 1'b0;
        win_addr    = '0;
        hit         = 1'b0;
        resp_fire   = 1'b0;
        resp_err    = 1'b0;
        resp_data   = '0;
`ifdef SPIFLASH_ARB_CACHE_EN
        cvalid_d    = cvalid_q;
        ctag_d      = ctag_q;
        cdata_d     = cdata_q;
`endif
        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    // On a tie the requester not granted last time wins.
                    win      = (m0_valid && m1_valid) ? ~last_q : m1_valid;
                    win_addr = win ? m1_addr : m0_addr;
                    grant_d  = win;
                    last_d   = win;
`ifdef SPIFLASH_ARB_CACHE_EN
                    hit      = cvalid_q && (ctag_q == win_addr);
`endif
                    if (hit) begin
`ifdef SPIFLASH_ARB_CACHE_EN
                        resp_data = cdata_q;
`endif
                        resp_fire = 1'b1;
                        state_d   = RESP;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = win_addr;
                        cnt_d       = '0;
                        state_d     = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    resp_fire = 1'b1;
                    resp_data = mem_rdata;
                    state_d   = RESP;
`ifdef SPIFLASH_ARB_CACHE_EN
                    cvalid_d  = 1'b1;
                    ctag_d    = mem_addr_q;
                    cdata_d   = mem_rdata;
`endif
                end else if (cnt_q == TO_LAST) begin
                    resp_fire = 1'b1;
                    resp_data = 32'hFFFF_FFFF;
                    resp_err  = 1'b1;
                    state_d   = RESP;
`ifdef SPIFLASH_ARB_CACHE_EN
                    cvalid_d  = 1'b0;
`endif
                end else begin
                    mem_valid_d = 1'b1;
                    cnt_d       = cnt_q + 16'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The ready pulse is registered on entry to RESP, so it lasts exactly the RESP cycle.
        if (resp_fire) begin
            if (grant_d) begin
                m1_ready_d = 1'b1;
                m1_rdata_d = resp_data;
                m1_err_d   = resp_err;
            end else begin
                m0_ready_d = 1'b1;
                m0_rdata_d = resp_data;
                m0_err_d   = resp_err;
            end
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign m0_ready  = m0_ready_q;
    assign m0_rdata  = m0_rdata_q;
    assign m0_err    = m0_err_q;
    assign m1_ready  = m1_ready_q;
    assign m1_rdata  = m1_rdata_q;
    assign m1_err    = m1_err_q;
endmodule

// File: tb/tb_spiflash_arb.sv
// Scoreboard bench for spiflash_arb: requester agents, flash responder and output monitor
// run as forked processes; scenario tasks check latency, ordering and hold behaviour.
module tb_spiflash_arb;
    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid, m0_ready, m1_ready, m0_err, m1_err;
    logic [23:0] m0_addr, m1_addr, mem_addr;
    logic [31:0] m0_rdata, m1_rdata, mem_rdata;
    logic        mem_valid, mem_ready;

    int vectors = 0, miscompares = 0;
    int cyc = 0, entry_cyc = 0, rdy_cyc = 0, memrdy_cyc = 0, req_cyc0 = 0, req_cyc1 = 0;
    int mem_lat = 5, pulse_cnt = 0;
    bit mem_en = 1'b1, exp_to = 1'b0;
    logic [23:0] q0[$], q1[$], addr_log[$];
    logic [32:0] sb0[$], sb1[$];
    logic        grant_log[$];

    spiflash_arb #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [23:0] a);
        return (a == 24'h000100) ? 32'hDEAD_BEEF : ({8'hC3, a} ^ 32'h5A5A_0000);
    endfunction

    task automatic cycle_count();
        forever begin @(posedge clk); cyc++; end
    endtask

    // Requester: holds valid until its ready pulse, then takes the next queued address.
    task automatic agent(input int id);
        logic [23:0] a;
        forever begin
            @(negedge clk);
            if (id == 0) begin
                if (reset) begin m0_valid = 1'b0; q0.delete(); sb0.delete(); end
                else if (m0_valid) begin if (m0_ready) m0_valid = 1'b0; end
                else if (q0.size() != 0) begin
                    a = q0.pop_front(); m0_addr = a; m0_valid = 1'b1; req_cyc0 = cyc;
                    sb0.push_back(exp_to ? {32'hFFFF_FFFF, 1'b1} : {model(a), 1'b0});
                end
            end else begin
                if (reset) begin m1_valid = 1'b0; q1.delete(); sb1.delete(); end
                else if (m1_valid) begin if (m1_ready) m1_valid = 1'b0; end
                else if (q1.size() != 0) begin
                    a = q1.pop_front(); m1_addr = a; m1_valid = 1'b1; req_cyc1 = cyc;
                    sb1.push_back(exp_to ? {32'hFFFF_FFFF, 1'b1} : {model(a), 1'b0});
                end
            end
        end
    endtask

    task automatic responder();
        int busy_cnt = 0, pulses_done = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (reset) busy_cnt = 0;
            else if (pulses_done != pulse_cnt) begin
                pulses_done++; mem_ready = 1'b1; mem_rdata = 32'h0BAD_0BAD;
            end else if (mem_valid && mem_en) begin
                if (busy_cnt == mem_lat) begin
                    mem_ready = 1'b1; mem_rdata = model(mem_addr); memrdy_cyc = cyc; busy_cnt = 0;
                end else busy_cnt++;
            end else busy_cnt = 0;
        end
    endtask

    task automatic monitor();
        logic prev_mv = 1'b0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (reset) prev_mv = 1'b0;
            else begin
                if (mem_valid && !prev_mv) begin entry_cyc = cyc; addr_log.push_back(mem_addr); end
                prev_mv = mem_valid;
                if (m0_ready || m1_ready) begin grant_log.push_back(m1_ready); rdy_cyc = cyc; end
                if (m0_ready && m1_ready) begin
                    vectors++; miscompares++; $display("FAIL both_ready: m0_ready=1 m1_ready=1 at cycle %0d", cyc);
                end
                if (m0_ready) begin
                    vectors++;
                    if (sb0.size() == 0) begin miscompares++; $display("FAIL m0_unexpected: ready at cycle %0d, none expected", cyc); end
                    else begin
                        e = sb0.pop_front();
                        if ({m0_rdata, m0_err} !== e) begin
                            miscompares++; $display("FAIL m0_resp: got %h/%b want %h/%b", m0_rdata, m0_err, e[32:1], e[0]);
                        end
                    end
                end
                if (m1_ready) begin
                    vectors++;
                    if (sb1.size() == 0) begin miscompares++; $display("FAIL m1_unexpected: ready at cycle %0d, none expected", cyc); end
                    else begin
                        e = sb1.pop_front();
                        if ({m1_rdata, m1_err} !== e) begin
                            miscompares++; $display("FAIL m1_resp: got %h/%b want %h/%b", m1_rdata, m1_err, e[32:1], e[0]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || sb0.size() != 0 || sb1.size() != 0 || m0_valid || m1_valid) && n < 300) begin
            @(negedge clk); n++;
        end
        if (n >= 300) begin vectors++; miscompares++; $display("FAIL %s_drain: still busy after %0d cycles, want done", tag, n); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        vectors++;
        if ({mem_valid, mem_addr, m0_ready, m0_rdata, m0_err, m1_ready, m1_rdata, m1_err} !== 93'b0) begin
            miscompares++; $display("FAIL reset_outputs: mem_valid=%b mem_addr=%h m0=%b/%h/%b m1=%b/%h/%b want all 0",
                                    mem_valid, mem_addr, m0_ready, m0_rdata, m0_err, m1_ready, m1_rdata, m1_err);
        end
    endtask

    task automatic test_tie();
        addr_log.delete(); grant_log.delete();
        q0.push_back(24'h000010); q1.push_back(24'h000020);
        drain("tie");
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1) begin
            miscompares++; $display("FAIL tie_order: %0d grants, first=%b want m0 then m1", grant_log.size(), grant_log[0]);
        end
        vectors++;
        if (addr_log.size() != 2 || addr_log[0] !== 24'h000010 || addr_log[1] !== 24'h000020) begin
            miscompares++; $display("FAIL tie_mem_addr: %0d addrs, first=%h want 000010 then 000020", addr_log.size(), addr_log[0]);
        end
    endtask

    task automatic test_back_to_back();
        grant_log.delete();
        q0.push_back(24'h000400); q0.push_back(24'h000404);
        q1.push_back(24'h000800); q1.push_back(24'h000804);
        drain("b2b");
        vectors++;
        if (grant_log.size() != 4) begin
            miscompares++; $display("FAIL b2b_count: got %0d grants want 4", grant_log.size());
        end else for (int i = 0; i < 4; i++) begin
            vectors++;
            if (grant_log[i] !== i[0]) begin
                miscompares++; $display("FAIL b2b_grant%0d: got m%0d want m%0d", i, grant_log[i], i[0]);
            end
        end
    endtask

    task automatic test_single_read();
        mem_lat = 5;
        q0.push_back(24'h000100);
        drain("single");
        vectors++;
        if (entry_cyc - req_cyc0 != 1) begin
            miscompares++; $display("FAIL miss_issue_lat: mem_valid %0d cycles after request want 1", entry_cyc - req_cyc0);
        end
        vectors++;
        if (memrdy_cyc - entry_cyc != 5 || rdy_cyc - memrdy_cyc != 1) begin
            miscompares++; $display("FAIL miss_resp_lat: mem_ready+%0d, m0_ready+%0d want 5 and 1", memrdy_cyc - entry_cyc, rdy_cyc - memrdy_cyc);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if ({m0_ready, m0_rdata, m0_err} !== {1'b0, 32'hDEAD_BEEF, 1'b0}) begin
            miscompares++; $display("FAIL hold_rdata: got %b/%h/%b want 0/deadbeef/0", m0_ready, m0_rdata, m0_err);
        end
    endtask

    task automatic test_timeout();
        int na, ng;
        mem_en = 1'b0; exp_to = 1'b1;
        q1.push_back(24'h000030);
        drain("timeout");
        mem_en = 1'b1; exp_to = 1'b0;
        vectors++;
        if (rdy_cyc - entry_cyc != 8) begin
            miscompares++; $display("FAIL timeout_lat: m1_ready %0d cycles after BUSY entry want 8", rdy_cyc - entry_cyc);
        end
        na = addr_log.size(); ng = grant_log.size();
        pulse_cnt++;
        repeat (6) @(negedge clk);
        vectors++;
        if ({m1_rdata, m1_err} !== {32'hFFFF_FFFF, 1'b1} || grant_log.size() != ng || addr_log.size() != na || mem_valid !== 1'b0) begin
            miscompares++; $display("FAIL late_pulse: m1=%h/%b grants+%0d reqs+%0d mem_valid=%b want ffffffff/1 +0 +0 0",
                                    m1_rdata, m1_err, grant_log.size() - ng, addr_log.size() - na, mem_valid);
        end
    endtask

    task automatic test_timeout_boundary();
        mem_lat = 7;
        q0.push_back(24'h000200);
        drain("boundary");
        mem_lat = 5;
        vectors++;
        if (memrdy_cyc - entry_cyc != 7 || rdy_cyc - entry_cyc != 8) begin
            miscompares++; $display("FAIL boundary_lat: mem_ready+%0d m0_ready+%0d want 7 and 8", memrdy_cyc - entry_cyc, rdy_cyc - entry_cyc);
        end
    endtask

    task automatic test_cache();
        int n;
        n = addr_log.size();
        q0.push_back(24'h000040);
        drain("cache1");
        vectors++;
        if (addr_log.size() != n + 1) begin
            miscompares++; $display("FAIL cache_first_miss: %0d flash reads want 1", addr_log.size() - n);
        end
        n = addr_log.size();
        q0.push_back(24'h000040);
        drain("cache2");
`ifdef SPIFLASH_ARB_CACHE_EN
        vectors++;
        if (addr_log.size() != n || rdy_cyc - req_cyc0 != 1) begin
            miscompares++; $display("FAIL cache_hit: %0d flash reads, latency %0d want 0 and 1", addr_log.size() - n, rdy_cyc - req_cyc0);
        end
`else
        vectors++;
        if (addr_log.size() != n + 1) begin
            miscompares++; $display("FAIL nocache_reread: %0d flash reads want 1", addr_log.size() - n);
        end
`endif
    endtask

    task automatic test_reset_busy();
        int n, ng;
        bit seen = 1'b0;
        mem_en = 1'b0;
        q0.push_back(24'h000050);
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = mem_valid; end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL rst_busy_start: mem_valid=0 want 1"); end
        repeat (2) @(negedge clk);
        ng = grant_log.size();
        #2 reset = 1'b1;
        #1 test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mem_en = 1'b1;
        repeat (15) @(negedge clk);
        vectors++;
        if (grant_log.size() != ng || m0_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_no_pulse: %0d ready pulses after reset want 0", grant_log.size() - ng);
        end
        n = addr_log.size();
        q0.push_back(24'h000040);
        drain("rst_reread");
        vectors++;
        if (addr_log.size() != n + 1) begin
            miscompares++; $display("FAIL rst_cache_clear: %0d flash reads want 1", addr_log.size() - n);
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_valid = 1'b0; m1_valid = 1'b0; m0_addr = '0; m1_addr = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        fork
            cycle_count();
            agent(0);
            agent(1);
            responder();
            monitor();
        join_none
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_tie();
        test_back_to_back();
        test_single_read();
        test_timeout();
        test_timeout_boundary();
        test_cache();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
